// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth derivation and gray/binary pointer
// conversion, used by both the write and read sides of the FIFO.
package fifo_pkg;

  // Widest pointer the conversion helpers handle. Narrower pointers are
  // zero-extended on the way in and truncated on the way out. This is
  // lossless because leading zeros are invariant under both conversions.
  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_word_t;

  // Occupancy of the 2-entry write-side skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry valid/ready skid buffer feeding the FIFO write port.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   BUF_EMPTY | no word held, w_en low
//   BUF_ONE   | output register holds the next word to write
//   BUF_TWO   | output and skid registers both hold words, s_ready low
//
// The word in the output register is written on every cycle where full is
// low. A word that arrives while the output register is stalled parks in
// the skid register. s_ready is registered and drops as soon as the skid
// register is occupied, so the producer never sees a lost word.
module wr_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  input  logic                  full_i,
  output logic                  w_en_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  out_valid_o
);

  buf_state_e            state_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic                  s_ready_q;
  logic                  accept;
  logic                  drain;

  assign accept      = s_valid_i & s_ready_q;
  assign drain       = out_valid_q & ~full_i;

  assign w_en_o      = drain;
  assign wdata_o     = out_data_q;
  assign s_ready_o   = s_ready_q;
  assign out_valid_o = out_valid_q;

  // Occupancy FSM: move words output <- skid <- producer, stalling on full.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= BUF_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
      s_ready_q   <= 1'b0;
    end else begin
      s_ready_q <= 1'b1;
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            out_data_q  <= s_data_i;
            out_valid_q <= 1'b1;
            state_q     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (drain) begin
            if (accept) begin
              out_data_q <= s_data_i;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= BUF_EMPTY;
            end
          end else if (accept) begin
            skid_data_q <= s_data_i;
            state_q     <= BUF_TWO;
            s_ready_q   <= 1'b0;
          end
        end
        BUF_TWO: begin
          // s_ready is low here, so no new word can arrive this cycle.
          if (drain) begin
            out_data_q <= skid_data_q;
            state_q    <= BUF_ONE;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= BUF_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-side front end of the async FIFO. It buffers the producer stream,
// drives the write strobe while full is low, and reports the write-domain
// fill level, almost_full and a saturating count of stalled cycles.
module wr_ingress_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned STALL_W    = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  input  logic [PTR_WIDTH:0]    b_wptr,
  input  logic [PTR_WIDTH:0]    g_rptr_sync,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [PTR_WIDTH:0]    wr_level,
  output logic                  almost_full,
  input  logic                  stall_clr,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam int unsigned        DEPTH     = fifo_depth(PTR_WIDTH);
  localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic                 out_valid;
  logic [PTR_WIDTH:0]   rbin;
  logic [PTR_WIDTH:0]   level_d;
  logic [PTR_WIDTH:0]   wr_level_q;
  logic                 almost_full_q;
  logic [STALL_W-1:0]   stall_cnt_q;

  wr_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready),
    .full_i      (full),
    .w_en_o      (w_en),
    .wdata_o     (wdata),
    .out_valid_o (out_valid)
  );

  // The extra pointer MSB makes the modular difference correct across wrap.
  // The read pointer lags through the synchronizer, so the level can only
  // over-report, never under-report.
  assign rbin    = (PTR_WIDTH+1)'(gray2bin(ptr_word_t'(g_rptr_sync)));
  assign level_d = b_wptr - rbin;

  assign wr_level    = wr_level_q;
  assign almost_full = almost_full_q;
  assign stall_cnt   = stall_cnt_q;

  // Register the fill level and the threshold on the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_level_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_level_q    <= level_d;
      almost_full_q <= (level_d >= AF_THRESH);
    end
  end

  // Count the cycles where a word is waiting on full. The clear wins over a
  // same-cycle stall.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_clr) begin
      stall_cnt_q <= '0;
    end else if (out_valid && full && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
